dmem_byte_ctrl: RTL and testbench

- Data-memory responder for the RV32 subset: consumes the control unit's memory commands (WEmem, Lreg) plus address/store data from the datapath.
- Serialises each access onto an 8-bit-wide synchronous SRAM port: word = 4 little-endian byte beats, byte = 1 beat.
- Returns load data (LW word, LBU zero-extended byte) with a valid pulse.
- Stalls the core through a ready/busy handshake while a sequence is in flight.

---
 rtl/dmem_byte_ctrl_pkg.sv | 23 ++
 rtl/dmem_byte_ctrl_lane_asm.sv | 32 +++
 rtl/dmem_byte_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_dmem_byte_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_byte_ctrl_pkg.sv
// Shared encodings for the byte-serial data-memory controller (package dmem_pkg).
package dmem_pkg;

  localparam logic [1:0] WEMEM_NONE = 2'b00;
  localparam logic [1:0] WEMEM_WORD = 2'b01;
  localparam logic [1:0] WEMEM_BYTE = 2'b10;
  localparam logic [1:0] WEMEM_ILL  = 2'b11;

  localparam int BEATS_WORD = 4;
  localparam int BEATS_BYTE = 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT
  } dmem_state_e;

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[8*lane +: 8];
  endfunction

endpackage

// File: rtl/dmem_byte_ctrl_lane_asm.sv
// Byte-lane assembly register for load data (module dmem_lane_asm).
// word_o presents the value including any capture happening this cycle.
module dmem_lane_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        cap_i,
  input  logic [1:0]  lane_i,
  input  logic [7:0]  byte_i,
  input  logic        zext_i,
  output logic [31:0] word_o
);

  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (cap_i) begin
      data_d[8*lane_i +: 8] = byte_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign word_o = zext_i ? {24'b0, data_d[7:0]} : data_d;

endmodule

// File: rtl/dmem_byte_ctrl.sv
// Byte-serial data-memory responder: word = 4 LE beats, byte = 1 beat.
// Optional DMEM_MISALIGN_TRAP_EN adds a misalign pulse for unaligned word accesses.
//   state   | meaning
//   IDLE    | ready; accepts a request
//   WR      | issuing write beats
//   RD      | issuing read beats
//   RD_WAIT | final read byte arrives; rdata/rvalid update at exit
module dmem_byte_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        WEmem,
  input  logic              rd_req,
  input  logic              Lreg,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  dmem_state_e       state_q, state_d;
  logic [1:0]        cnt_q, cnt_d, cnt_nxt, last_idx;
  logic [ADDR_W-1:0] base_q, base_d, base_req;
  logic [31:0]       wdata_q, wdata_d;
  logic              byte_q, byte_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              cap_vld_q;
  logic [1:0]        cap_lane_q;
  logic              misalign_q, misalign_d;
  logic              asm_clr;
  logic [31:0]       asm_word;
  logic              is_store, is_load, word_acc, trap;

  assign cnt_nxt  = cnt_q + 2'd1;
  assign last_idx = byte_q ? 2'(BEATS_BYTE - 1) : 2'(BEATS_WORD - 1);

  // Request decode; a store wins over rd_req.
  assign is_store = (WEmem == WEMEM_WORD) || (WEmem == WEMEM_BYTE);
  assign is_load  = (WEmem == WEMEM_NONE) && rd_req;
  assign word_acc = (WEmem == WEMEM_WORD) || (is_load && !Lreg);
  assign base_req = word_acc ? {addr[ADDR_W-1:2], 2'b00} : addr;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign trap = word_acc && (addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    misalign_d  = 1'b0;
    asm_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (trap) begin
            misalign_d = 1'b1;
          end else if (is_store || is_load) begin
            state_d    = is_store ? WR : RD;
            cnt_d      = 2'd0;
            base_d     = base_req;
            wdata_d    = wdata;
            byte_d     = !word_acc;
            ram_en_d   = 1'b1;
            ram_we_d   = is_store;
            ram_addr_d = base_req;
            if (is_store) ram_wdata_d = wdata[7:0];
            asm_clr    = is_load;
          end
        end
      end
      WR: begin
        if (cnt_q == last_idx) begin
          state_d = IDLE;
        end else begin
          cnt_d       = cnt_nxt;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = base_q + ADDR_W'(cnt_nxt);
          ram_wdata_d = lane_byte(wdata_q, cnt_nxt);
        end
      end
      RD: begin
        if (cnt_q == last_idx) begin
          state_d = RD_WAIT;
        end else begin
          cnt_d      = cnt_nxt;
          ram_en_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(cnt_nxt);
        end
      end
      RD_WAIT: begin
        rdata_d  = asm_word;
        rvalid_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      byte_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      cap_vld_q   <= 1'b0;
      cap_lane_q  <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      // SRAM returns read data one cycle after the beat; remember its lane.
      cap_vld_q   <= ram_en_q && !ram_we_q;
      cap_lane_q  <= cnt_q;
      misalign_q  <= misalign_d;
    end
  end

  dmem_lane_asm u_lane_asm (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (asm_clr),
    .cap_i  (cap_vld_q),
    .lane_i (cap_lane_q),
    .byte_i (ram_rdata),
    .zext_i (byte_q),
    .word_o (asm_word)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Scoreboard bench for dmem_byte_ctrl: driver pushes expected beats/loads, monitor pops and compares.
module tb_dmem_byte_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  WEmem = 2'b00;
  logic        rd_req = 1'b0;
  logic        Lreg = 1'b0;
  logic [9:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, busy, ram_en, ram_we;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  dmem_byte_ctrl #(.ADDR_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .WEmem     (WEmem),
    .rd_req    (rd_req),
    .Lreg      (Lreg),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    .misalign  (misalign)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment SRAM: synchronous, read data valid the cycle after the beat.
  bit [7:0] sram [1024];
  always @(posedge clk) begin
    if (ram_en && ram_we)  sram[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= sram[ram_addr];
  end

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic       we;
    logic [7:0] wd;
  } beat_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } load_t;

  beat_t beat_q[$];
  load_t load_q[$];
  bit [7:0] model_mem [1024];

  // Driver-owned signalling to the monitor.
  bit mon_en = 1'b0;
  bit end_req = 1'b0;
  int busy_lo = 0, busy_hi = 0;
  int exp_mis_cyc = -1;

  // Monitor-owned state.
  int n_pass = 0, n_total = 0;
  logic [31:0] held = '0;
  bit end_done = 1'b0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp_v, cyc);
  endtask

  initial begin
    bit    exp_rdy;
    beat_t b;
    load_t l;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_rdy = !(cyc >= busy_lo && cyc < busy_hi);
        chk(req_ready == exp_rdy, "req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        chk(busy == !exp_rdy, "busy", {31'b0, busy}, {31'b0, !exp_rdy});
        if (rvalid) begin
          if (load_q.size() == 0) begin
            chk(1'b0, "unexpected_rvalid", rdata, held);
          end else begin
            l = load_q.pop_front();
            chk(cyc == l.cyc, "rvalid_cycle", cyc, l.cyc);
            chk(rdata == l.data, "load_data", rdata, l.data);
            held = l.data;
          end
        end
        chk(rdata == held, "rdata_hold", rdata, held);
        if (ram_en) begin
          if (beat_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", {13'b0, ram_addr, ram_we, ram_wdata}, 32'h0);
          end else begin
            b = beat_q.pop_front();
            chk(cyc == b.cyc, "beat_cycle", cyc, b.cyc);
            chk(ram_addr == b.addr && ram_we == b.we && (!b.we || ram_wdata == b.wd), "beat",
                {13'b0, ram_addr, ram_we, ram_wdata}, {13'b0, b.addr, b.we, b.wd});
          end
        end else begin
          chk(ram_we == 1'b0 && ram_addr == '0 && ram_wdata == '0, "ram_idle_zero",
              {13'b0, ram_addr, ram_we, ram_wdata}, 32'h0);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        chk(misalign == (cyc == exp_mis_cyc), "misalign", {31'b0, misalign}, {31'b0, cyc == exp_mis_cyc});
`endif
        if (rst) held = '0;
        if (end_req && !end_done) begin
          chk(beat_q.size() == 0, "beats_drained", beat_q.size(), 0);
          chk(load_q.size() == 0, "loads_drained", load_q.size(), 0);
          end_done = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] we, input logic rd, input logic lreg,
                       input logic [9:0] a, input logic [31:0] wd);
    int         g, t, nb;
    bit         st, ld, wacc;
    logic [9:0] base, ba;
    load_t      l;
    g = 0;
    while (!req_ready && g < 50) begin
      step();
      g++;
    end
    if (!req_ready) begin
      $display("FAIL ready_timeout: req_ready stuck low, want high (cycle %0d)", cyc);
      $fatal(1);
    end
    t    = cyc;
    st   = (we == 2'b01) || (we == 2'b10);
    ld   = (we == 2'b00) && rd;
    wacc = (we == 2'b01) || (ld && !lreg);
    nb   = wacc ? 4 : 1;
    base = wacc ? {a[9:2], 2'b00} : a;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((st || ld) && wacc && a[1:0] != 2'b00) begin
      exp_mis_cyc = t + 1;
      st = 1'b0;
      ld = 1'b0;
    end
`endif
    if (st) begin
      for (int i = 0; i < nb; i++) begin
        ba = base + 10'(i);
        beat_q.push_back('{t + 1 + i, ba, 1'b1, wd[8*i +: 8]});
        model_mem[ba] = wd[8*i +: 8];
      end
      busy_lo = t + 1;
      busy_hi = t + nb + 1;
    end else if (ld) begin
      for (int i = 0; i < nb; i++) begin
        ba = base + 10'(i);
        beat_q.push_back('{t + 1 + i, ba, 1'b0, 8'h00});
      end
      if (wacc)
        l.data = {model_mem[base + 10'd3], model_mem[base + 10'd2],
                  model_mem[base + 10'd1], model_mem[base]};
      else
        l.data = {24'b0, model_mem[base]};
      l.cyc = t + nb + 2;
      load_q.push_back(l);
      busy_lo = t + 1;
      busy_hi = t + nb + 2;
    end
    WEmem     = we;
    rd_req    = rd;
    Lreg      = lreg;
    addr      = a;
    wdata     = wd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    WEmem     = 2'($urandom);
    rd_req    = 1'($urandom);
    addr      = 10'($urandom);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    issue(2'b01, 1'b0, 1'b0, 10'h104, 32'hDEADBEEF);
    issue(2'b10, 1'b0, 1'b0, 10'h105, 32'h000000A5);
    issue(2'b00, 1'b1, 1'b0, 10'h104, 32'h0);
    issue(2'b00, 1'b1, 1'b1, 10'h107, 32'h0);
    issue(2'b11, 1'b1, 1'b0, 10'h104, 32'h12345678);
    issue(2'b00, 1'b0, 1'b0, 10'h104, 32'h12345678);
    issue(2'b01, 1'b1, 1'b1, 10'h100, 32'h11223344);
    issue(2'b00, 1'b1, 1'b0, 10'h102, 32'h0);
    issue(2'b00, 1'b1, 1'b0, 10'h100, 32'h0);

    // Reset in the third cycle of a word load aborts it.
    issue(2'b00, 1'b1, 1'b0, 10'h104, 32'h0);
    t = cyc - 1;
    step();
    rst = 1'b1;
    step();
    while (beat_q.size() > 0 && beat_q[$].cyc >= t + 3) void'(beat_q.pop_back());
    load_q.delete();
    busy_hi = t + 3;
    rst = 1'b0;
    repeat (8) step();

    for (int k = 0; k < 150; k++) begin
      issue(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
            10'($urandom_range(0, 63)), $urandom);
    end

    repeat (10) step();
    end_req = 1'b1;
    for (int g = 0; g < 5 && !end_done; g++) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total + (end_done ? 0 : 1));
    $finish;
  end

endmodule
